pipelined_adder: RTL and testbench

//   WIDTH-bit adder split into STAGES registered carry segments, with valid/ready

---
 rtl/adder_pkg.sv | 23 ++
 rtl/adder_segment.sv | 39 +++
 rtl/pipelined_adder.sv | 152 +++++++++++++++
 tb/tb_pipelined_adder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared constants and helpers for the pipelined adder family.
//   - ADDER_DEF_WIDTH / ADDER_DEF_STAGES : default top-level parameters
//   - seg_width(w, s)                    : bits handled per pipeline segment
//   - fa_cell(x, y, c)                   : single-bit full-adder cell {co, s}
//   Optional feature macro used by the adder files: ADDER_OVF_EN.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int unsigned ADDER_DEF_WIDTH  = 16;
    localparam int unsigned ADDER_DEF_STAGES = 4;

    function automatic int unsigned seg_width(input int unsigned w, input int unsigned s);
        return w / s;
    endfunction

    // The team's original full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/adder_segment.sv
// -----------------------------------------------------------------------------
// adder_segment
//   Combinational SEG-bit ripple-carry adder made of full-adder cells.
//   Ports:
//     a, b  in   SEG  segment operand bits
//     ci    in   1    carry into bit 0 of the segment
//     s     out  SEG  segment sum bits
//     co    out  1    carry out of the segment MSB
//     cmsb  out  1    carry into the segment MSB (signed-overflow detection)
//   Optional feature macro of the adder family: ADDER_OVF_EN (consumer of cmsb).
// -----------------------------------------------------------------------------
module adder_segment
    import adder_pkg::*;
#(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           cmsb
);

    always_comb begin
        logic w_c;
        w_c  = ci;
        s    = '0;
        cmsb = 1'b0;
        for (int unsigned i = 0; i < SEG; i++) begin
            if (i == SEG - 1) begin
                cmsb = w_c;
            end
            {w_c, s[i]} = fa_cell(a[i], b[i], w_c);
        end
        co = w_c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit adder split into STAGES registered carry segments with
//   valid/ready handshakes. One operand pair per cycle, results in order,
//   latency STAGES cycles.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous active-high reset
//     in_valid   in   1      operand pair present
//     in_ready   out  1      block can accept this cycle
//     a, b       in   WIDTH  operands
//     cin        in   1      carry into bit 0
//     out_valid  out  1      result present
//     out_ready  in   1      downstream accepts result
//     sum        out  WIDTH  a + b + cin mod 2^WIDTH
//     cout       out  1      carry out of bit WIDTH-1
//     ovf        out  1      signed overflow (only when ADDER_OVF_EN is defined)
//   Configuration macro: ADDER_OVF_EN.
// -----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = ADDER_DEF_WIDTH,
    parameter int unsigned STAGES = ADDER_DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
    localparam int unsigned LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH (%0d) must be divisible by STAGES (%0d), 1 <= STAGES <= WIDTH",
               WIDTH, STAGES);
    end

    // Stage registers: operands travel whole, sum accumulates one segment per stage.
    logic             r_v [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];

    // What each stage sees on its input side, and what it would capture.
    logic             w_in_v [STAGES];
    logic [WIDTH-1:0] w_in_a [STAGES];
    logic [WIDTH-1:0] w_in_b [STAGES];
    logic [WIDTH-1:0] w_in_s [STAGES];
    logic             w_in_c [STAGES];
    logic [WIDTH-1:0] w_nx_s [STAGES];
    logic [SEG-1:0]   w_seg_s [STAGES];
    logic             w_co   [STAGES];
    logic             w_cmsb [STAGES];

    logic             w_advance;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_in_v[k] = in_valid;
            assign w_in_a[k] = a;
            assign w_in_b[k] = b;
            assign w_in_s[k] = '0;
            assign w_in_c[k] = cin;
        end else begin : g_body
            assign w_in_v[k] = r_v[k-1];
            assign w_in_a[k] = r_a[k-1];
            assign w_in_b[k] = r_b[k-1];
            assign w_in_s[k] = r_s[k-1];
            assign w_in_c[k] = r_c[k-1];
        end

        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (w_in_a[k][k*SEG +: SEG]),
            .b    (w_in_b[k][k*SEG +: SEG]),
            .ci   (w_in_c[k]),
            .s    (w_seg_s[k]),
            .co   (w_co[k]),
            .cmsb (w_cmsb[k])
        );

        logic [WIDTH-1:0] w_nx;
        always_comb begin
            w_nx                = w_in_s[k];
            w_nx[k*SEG +: SEG]  = w_seg_s[k];
        end
        assign w_nx_s[k] = w_nx;
    end

    // Inner stages capture data every advance (bubble contents are don't-care).
    // The last stage captures only real transactions so the outputs stay
    // frozen while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
        end else if (w_advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k] <= w_in_v[k];
                if (k != LAST || w_in_v[k]) begin
                    r_a[k] <= w_in_a[k];
                    r_b[k] <= w_in_b[k];
                    r_s[k] <= w_nx_s[k];
                    r_c[k] <= w_co[k];
                end
            end
        end
    end

    assign out_valid = r_v[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_c[LAST];

`ifdef ADDER_OVF_EN
    logic r_ovf;

    // Overflow = carry into MSB xor carry out of MSB, both from the last segment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_advance && w_in_v[LAST]) begin
            r_ovf <= w_co[LAST] ^ w_cmsb[LAST];
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: STAGES = 4 (main), 1 and 16.
module tb_pipelined_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_ready;

    logic [2:0]  w_ir;
    logic [2:0]  w_ov;
    logic [2:0]  w_co;
    logic [2:0]  w_of;
    logic [2:0]  w_or;
    logic [15:0] w_sum [3];

    int n_cmp = 0;
    int n_err = 0;

    // Per-DUT expectation FIFOs: {ovf, cout, sum}
    logic [17:0] mem [3][64];
    int          wp [3];
    int          rp [3];
    logic [17:0] held [3];
    int          run [3];
    int          maxrun [3];
    logic [17:0] act;

    assign w_or = {2'b11, out_ready};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_ir[0]),
        .a(a), .b(b), .cin(cin), .out_valid(w_ov[0]), .out_ready(w_or[0]),
        .sum(w_sum[0]), .cout(w_co[0])
`ifdef ADDER_OVF_EN
        , .ovf(w_of[0])
`endif
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_ir[1]),
        .a(a), .b(b), .cin(cin), .out_valid(w_ov[1]), .out_ready(w_or[1]),
        .sum(w_sum[1]), .cout(w_co[1])
`ifdef ADDER_OVF_EN
        , .ovf(w_of[1])
`endif
    );

    pipelined_adder #(.WIDTH(16), .STAGES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_ir[2]),
        .a(a), .b(b), .cin(cin), .out_valid(w_ov[2]), .out_ready(w_or[2]),
        .sum(w_sum[2]), .cout(w_co[2])
`ifdef ADDER_OVF_EN
        , .ovf(w_of[2])
`endif
    );

`ifndef ADDER_OVF_EN
    assign w_of = '0;
`endif

    // Reference: plain integer arithmetic, signed overflow from range check.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] u;
        int          s;
        logic        of;
        u  = {1'b0, x} + {1'b0, y} + {16'd0, c};
        s  = int'($signed(x)) + int'($signed(y)) + int'({31'd0, c});
        of = (s > 32767) || (s < -32768);
`ifndef ADDER_OVF_EN
        of = 1'b0;
`endif
        return {of, u};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    // Compare process: every cycle, every DUT.
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                wp[d]   = 0;
                rp[d]   = 0;
                held[d] = '0;
                run[d]  = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                act = {w_of[d], w_co[d], w_sum[d]};
                n_cmp++;
                if (w_ov[d]) begin
                    run[d]++;
                    if (run[d] > maxrun[d]) maxrun[d] = run[d];
                    if (rp[d] == wp[d]) begin
                        n_err++;
                        $display("FAIL spurious_out dut%0d: got %h, required no output", d, act);
                    end else begin
                        if (act !== mem[d][rp[d] % 64]) begin
                            n_err++;
                            $display("FAIL result dut%0d: got %h, required %h", d, act, mem[d][rp[d] % 64]);
                        end
                        if (w_or[d]) rp[d]++;
                    end
                    held[d] = act;
                end else begin
                    run[d] = 0;
                    if (act !== held[d]) begin
                        n_err++;
                        $display("FAIL idle_hold dut%0d: got %h, required %h", d, act, held[d]);
                    end
                end
                if (in_valid && w_ir[d]) begin
                    mem[d][wp[d] % 64] = model(a, b, cin);
                    wp[d]++;
                end
            end
            n_cmp++;
            if (w_ir[0] !== (!w_ov[0] || out_ready)) begin
                n_err++;
                $display("FAIL in_ready: got %b, required %b", w_ir[0], (!w_ov[0] || out_ready));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        int n;
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!w_ir[0] && n < 50);
        chk("send_accept", 32'(w_ir[0]), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!w_ov[0] && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_valid", 32'(w_ov[0]), 32'd1);
    endtask

    logic [15:0] vec_a [6] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hABCD, 16'h7FFF};
    logic [15:0] vec_b [6] = '{16'h4321, 16'hFFFF, 16'h8000, 16'hF0F0, 16'h1111, 16'h7FFF};
    logic        vec_c [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int n;
        int cnt;
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        for (int d = 0; d < 3; d++) maxrun[d] = 0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("reset_out_valid", 32'(w_ov[0]), 32'd0);
        chk("reset_sum", 32'(w_sum[0]), 32'd0);
        chk("reset_in_ready", 32'(w_ir[0]), 32'd1);

        // Test 1: latency and segment-boundary carry
        send(16'h00FF, 16'h0001, 1'b0);
        wait_valid(n);
        chk("t1_latency", 32'(n + 1), 32'd4);
        chk("t1_sum", 32'(w_sum[0]), 32'h0100);
        chk("t1_cout", 32'(w_co[0]), 32'd0);
        cyc(20);

        // Test 2: wrap-around through all boundaries
        send(16'hFFFF, 16'h0000, 1'b1);
        wait_valid(n);
        chk("t2_sum", 32'(w_sum[0]), 32'h0000);
        chk("t2_cout", 32'(w_co[0]), 32'd1);
        chk("t2_ovf", 32'(w_of[0]), 32'd0);
        cyc(20);

        // Test 3: six back-to-back transfers on all three depths
        for (int d = 0; d < 3; d++) maxrun[d] = 0;
        for (int i = 0; i < 6; i++) send(vec_a[i], vec_b[i], vec_c[i]);
        cyc(25);
        chk("t3_run_s4", 32'(maxrun[0]), 32'd6);
        chk("t3_run_s1", 32'(maxrun[1]), 32'd6);
        chk("t3_run_s16", 32'(maxrun[2]), 32'd6);
        chk("model_pin_ffff", 32'(model(16'hFFFF, 16'hFFFF, 1'b1)), 32'h1FFFF);

        // Test 4: output stall
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h0F00, 16'h0100, 1'b1);
        send(16'h00FF, 16'h00FF, 1'b0);
        wait_valid(n);
        chk("t4_sum_first", 32'(w_sum[0]), 32'h3333);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t4_stall_in_ready", 32'(w_ir[0]), 32'd0);
            chk("t4_stall_valid", 32'(w_ov[0]), 32'd1);
            chk("t4_stall_sum", 32'(w_sum[0]), 32'h3333);
        end
        out_ready = 1'b1;
        cyc(1);
        chk("t4_second", 32'(w_sum[0]), 32'h1001);
        cyc(1);
        chk("t4_third", 32'(w_sum[0]), 32'h01FE);
        cyc(15);
        chk("t4_drained", 32'(rp[0]), 32'(wp[0]));

        // Test 5: reset with transactions in flight
        send(16'h0001, 16'h0002, 1'b0);
        send(16'h0003, 16'h0004, 1'b1);
        send(16'h0005, 16'h0006, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_out_valid", 32'(w_ov[0]), 32'd0);
        chk("t5_sum", 32'(w_sum[0]), 32'd0);
        chk("t5_cout", 32'(w_co[0]), 32'd0);
        chk("t5_sum_s16", 32'(w_sum[2]), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (w_ov != 3'b000) cnt++;
        end
        chk("t5_nothing_emerges", 32'(cnt), 32'd0);

`ifdef ADDER_OVF_EN
        // Test 6: signed overflow flag
        send(16'h7FFF, 16'h0001, 1'b0);
        wait_valid(n);
        chk("t6_ovf_pos", 32'(w_of[0]), 32'd1);
        chk("t6_sum_pos", 32'(w_sum[0]), 32'h8000);
        cyc(20);
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_valid(n);
        chk("t6_ovf_neg", 32'(w_of[0]), 32'd0);
        chk("t6_cout_neg", 32'(w_co[0]), 32'd1);
        chk("t6_sum_neg", 32'(w_sum[0]), 32'h0000);
        cyc(20);
`endif

        for (int d = 0; d < 3; d++) chk("final_drained", 32'(rp[d]), 32'(wp[d]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
